ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/ifetch_queue.sv | 51 +++++
 rtl/ifetch_ctrl.sv | 132 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer (ifetch_ctrl).
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  localparam int          ENTRY_W          = $bits(entry_t);
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO: DEPTH entries (power of two), push/pop/flush, exposes count and head.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] head,
  output logic [AW:0]        count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Storage carries no reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, fills the prefetch queue from the ROM,
// handles redirects and halt. Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          Q_DEPTH    = 4,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        halt_req,
  output logic        busy,
  output logic        fault
);

  localparam int AW = $clog2(Q_DEPTH);

  if (Q_DEPTH < 2 || (Q_DEPTH & (Q_DEPTH - 1)) != 0 || IMEM_WORDS < 1) begin : g_bad_params
    $error("ifetch_ctrl: Q_DEPTH must be a power of two >= 2 and IMEM_WORDS >= 1");
  end

  // Handshake: decode takes the head entry on any edge where out_valid and out_ready
  // are both high; out_pc/out_ins hold steady while out_valid is high and out_ready low.

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redir_target;
  logic        misalign;
  logic        pop;
  logic        push;
  logic        q_full;
  logic [AW:0] count;
  entry_t      head;
  entry_t      wentry;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign misalign     = redir_valid & (redir_pc[1:0] != 2'b00);
  assign redir_target = redir_pc;
  assign fault        = fault_q;
`else
  logic redir_lsb_unused;

  assign misalign         = 1'b0;
  assign redir_target     = align_pc(redir_pc);
  assign redir_lsb_unused = ^redir_pc[1:0];
  assign fault            = 1'b0;
`endif

  assign q_full = (count == (AW+1)'(Q_DEPTH));
  assign pop    = out_valid & out_ready;
  // A redirect cycle never pushes: the ROM word at the old PC is already stale.
  assign push   = (state_q == RUN) & ~halt_req & ~redir_valid & (~q_full | pop);

  assign wentry.pc  = fetch_pc_q;
  assign wentry.ins = imem_ins;

  ifetch_queue #(
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir_valid),
    .wdata (wentry),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    fault_d    = fault_q;
`endif

    if (redir_valid) begin
      fetch_pc_d = redir_target;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt_req)  state_d = HALT;
      HALT:    if (!halt_req) state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    if (misalign) begin
      state_d = FAULT;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc  : 32'd0;
  assign out_ins   = out_valid ? head.ins : 32'd0;
  assign busy      = (state_q == RUN) & ~q_full;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam int          QD  = 4;
  localparam int          IW  = 256;
  localparam logic [31:0] RPC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_ins;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'd0;
  logic        halt_req = 1'b0;
  logic        busy;
  logic        fault;

  always #5 clk = ~clk;

  logic [31:0] rom [IW];
  assign imem_ins = rom[(imem_addr >> 2) % IW];

  ifetch_ctrl #(
    .RESET_PC   (RPC),
    .Q_DEPTH    (QD),
    .IMEM_WORDS (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_ins    (imem_ins),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_ins     (out_ins),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halt_req    (halt_req),
    .busy        (busy),
    .fault       (fault)
  );

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];     // {pc, ins} entries decode should see, oldest first
  logic [31:0] m_pc;
  bit          m_started;    // first edge after reset release has passed
  bit          m_halted;
  bit          m_fault;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return rom[(pc >> 2) % IW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc      = RPC;
    m_started = 1'b0;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
  endtask

  // Apply one clock edge's worth of spec rules to the model.
  task automatic model_step();
    bit fetching, pop, push;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fetching = m_started && !m_halted && !m_fault;
    pop      = (exp_q.size() != 0) && out_ready;
    push     = fetching && !halt_req && !redir_valid && ((exp_q.size() < QD) || pop);
    if (pop) void'(exp_q.pop_front());
    if (redir_valid) begin
      exp_q.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
      m_pc = redir_pc;
      if (redir_pc[1:0] != 2'b00) m_fault = 1'b1;
`else
      m_pc = redir_pc & 32'hFFFF_FFFC;
`endif
    end else if (push) begin
      exp_q.push_back({m_pc, rom_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    if (!m_started)    m_started = 1'b1;
    else if (!m_fault) m_halted = halt_req;
  endtask

  task automatic compare();
    logic [63:0] h;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("out_pc", out_pc, h[63:32]);
      check("out_ins", out_ins, h[31:0]);
    end
    check("imem_addr", imem_addr, m_pc);
    check("busy", busy, m_started && !m_halted && !m_fault && (exp_q.size() < QD));
    check("fault", fault, m_fault);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_ins", out_ins, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_imem_addr", imem_addr, RPC);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    for (int i = 0; i < IW; i++) rom[i] = $urandom;
    rom[0] = 32'h0050_0193;
    rom[1] = 32'h0031_8233;

    @(negedge clk);

    // Reset release latency and first two fetches.
    out_ready = 1'b1;
    do_reset();
    tick();
    check("t1_edge0_valid", out_valid, 1'b0);
    tick();
    check("t1_edge1_valid", out_valid, 1'b1);
    check("t1_pc0", out_pc, 32'h0);
    check("t1_ins0", out_ins, 32'h0050_0193);
    tick();
    check("t1_pc1", out_pc, 32'h4);
    check("t1_ins1", out_ins, 32'h0031_8233);

    // Back-pressure fills the queue, then drains in order with no gaps.
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("t2_busy_full", busy, 1'b0);
    check("t2_addr_frozen", imem_addr, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_drain_pc", out_pc, 32'(i * 4));
      tick();
    end
    check("t2_steady_valid", out_valid, 1'b1);
    check("t2_steady_busy", busy, 1'b0);
    check("t2_steady_addr", imem_addr, 32'h24);

    // Redirect with three entries queued: one bubble, then the target.
    out_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    check("t3_head_before", out_pc, 32'h0);
    redir_valid = 1'b1;
    redir_pc    = 32'h20;
    out_ready   = 1'b1;
    tick();
    redir_valid = 1'b0;
    check("t3_bubble", out_valid, 1'b0);
    tick();
    check("t3_target_valid", out_valid, 1'b1);
    check("t3_target_pc", out_pc, 32'h20);
    check("t3_target_ins", out_ins, rom[8]);

    // Halt drains the queue without new fetches, then resumes sequentially.
    halt_req = 1'b1;
    repeat (5) tick();
    check("t4_drained", out_valid, 1'b0);
    check("t4_held_addr", imem_addr, 32'h24);
    halt_req = 1'b0;
    tick();
    tick();
    check("t4_resume_pc", out_pc, 32'h24);

    // Misaligned redirect.
    redir_valid = 1'b1;
    redir_pc    = 32'h22;
    tick();
    redir_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    repeat (5) tick();
    check("t5_fault", fault, 1'b1);
    check("t5_no_valid", out_valid, 1'b0);
    check("t5_addr", imem_addr, 32'h22);
`else
    tick();
    check("t5_aligned_pc", out_pc, 32'h20);
    check("t5_no_fault", fault, 1'b0);
`endif

    // Randomized traffic, including PC wrap at 2^32 and occasional mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      redir_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 9))
        0:       redir_pc = 32'hFFFF_FFF0;
        1:       redir_pc = 32'($urandom_range(0, 255) * 4) | 32'h2;
        default: redir_pc = 32'($urandom_range(0, 511) * 4);
      endcase
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
